// File: rtl/johnson_decoder_monitor.sv
// Decodes sampled Johnson counter states into a step index and monitors the
// sequence. It locks after LOCK_N consecutive correct successors and counts illegal/out-of-sequence events.
module johnson_decoder_monitor #(
    parameter int WIDTH  = 4,
    parameter int IDX_W  = 3,
    parameter int LOCK_N = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] q_in,
    output logic [IDX_W-1:0] idx,
    output logic             idx_valid,
    output logic             illegal,
    output logic             seq_err,
    output logic             locked,
    output logic [7:0]       err_count
);

    localparam int SEQ_LEN = 2 * WIDTH;
    localparam int CNT_W   = (LOCK_N < 2) ? 1 : $clog2(LOCK_N + 1);

    localparam logic [0:0] S_UNLOCKED = 1'b0;
    localparam logic [0:0] S_LOCKED   = 1'b1;

    logic [0:0]       state;
    logic [CNT_W-1:0] lock_cnt;
    logic             ref_valid;

    logic             legal;
    logic [IDX_W-1:0] dec_idx;
    logic [IDX_W-1:0] succ_idx;
    logic             is_succ;
    logic             cnt_done;

    // Step k < WIDTH+1: top k bits set; beyond that, top k-WIDTH bits cleared.
    function automatic logic [WIDTH-1:0] code_of(input int k);
        logic [WIDTH-1:0] c;
        for (int i = 0; i < WIDTH; i++) begin
            c[i] = (k <= WIDTH) ? (i >= WIDTH - k) : (i < SEQ_LEN - k);
        end
        return c;
    endfunction

    always_comb begin
        legal   = 1'b0;
        dec_idx = '0;
        for (int k = 0; k < SEQ_LEN; k++) begin
            if (q_in == code_of(k)) begin
                legal   = 1'b1;
                dec_idx = IDX_W'(k);
            end
        end
    end

    // idx always holds the last legal index, so it doubles as the reference.
    assign succ_idx = (idx == IDX_W'(SEQ_LEN - 1)) ? '0 : idx + 1'b1;
    assign is_succ  = ref_valid && (dec_idx == succ_idx);
    assign cnt_done = ({1'b0, lock_cnt} + 1'b1) >= (CNT_W + 1)'(LOCK_N);
    assign locked   = (state == S_LOCKED);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_UNLOCKED;
            lock_cnt  <= '0;
            ref_valid <= 1'b0;
            idx       <= '0;
            idx_valid <= 1'b0;
            illegal   <= 1'b0;
            seq_err   <= 1'b0;
            err_count <= '0;
        end else begin
            idx_valid <= 1'b0;
            illegal   <= 1'b0;
            seq_err   <= 1'b0;
            if (valid_in) begin
                if (!legal) begin
                    illegal   <= 1'b1;
                    lock_cnt  <= '0;
                    err_count <= (err_count == 8'hFF) ? err_count : err_count + 8'd1;
                    if (state == S_LOCKED) begin
                        state     <= S_UNLOCKED;
                        ref_valid <= 1'b0;
                    end
                end else begin
                    idx       <= dec_idx;
                    idx_valid <= 1'b1;
                    ref_valid <= 1'b1;
                    if (state == S_LOCKED) begin
                        if (!is_succ) begin
                            seq_err   <= 1'b1;
                            err_count <= (err_count == 8'hFF) ? err_count : err_count + 8'd1;
                            state     <= S_UNLOCKED;
                            lock_cnt  <= '0;
                        end
                    end else if (is_succ) begin
                        if (cnt_done) begin
                            state    <= S_LOCKED;
                            lock_cnt <= '0;
                        end else begin
                            lock_cnt <= lock_cnt + 1'b1;
                        end
                    end else begin
                        lock_cnt <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_johnson_decoder_monitor.sv
// Bench for johnson_decoder_monitor: directed vector table, hand-written
// corner sequences and randomized traffic scored against an index-level model.
module tb_johnson_decoder_monitor;

    localparam int W      = 4;
    localparam int IW     = 3;
    localparam int LOCKN  = 2;
    localparam int SEQ    = 2 * W;
    localparam int OUT_W  = IW + 4 + 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          valid_in = 1'b0;
    logic [W-1:0]  q_in = '0;
    logic [IW-1:0] idx;
    logic          idx_valid, illegal, seq_err, locked;
    logic [7:0]    err_count;

    johnson_decoder_monitor #(.WIDTH(W), .IDX_W(IW), .LOCK_N(LOCKN)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .q_in(q_in),
        .idx(idx), .idx_valid(idx_valid), .illegal(illegal), .seq_err(seq_err),
        .locked(locked), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [OUT_W-1:0] exp_q[$];
    logic [W-1:0]     codes[SEQ];
    logic [W-1:0]     bad_codes[8];

    typedef struct {
        logic             v;
        logic [W-1:0]     q;
        logic [OUT_W-1:0] exp;
    } vec_t;
    vec_t vecs[16];

    // index-level reference model
    int m_idx, m_run, m_err;
    bit m_ref_valid, m_locked;

    function automatic logic [OUT_W-1:0] pack(input int i, input bit iv, input bit ill,
                                               input bit se, input bit lk, input int err);
        return {IW'(i), iv, ill, se, lk, 8'(err)};
    endfunction

    function automatic vec_t mk(input logic v, input logic [W-1:0] q, input logic [OUT_W-1:0] e);
        vec_t t;
        t.v = v; t.q = q; t.exp = e;
        return t;
    endfunction

    function automatic logic [OUT_W-1:0] actual();
        return {idx, idx_valid, illegal, seq_err, locked, err_count};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_idx = 0; m_run = 0; m_err = 0; m_ref_valid = 0; m_locked = 0;
    endtask

    task automatic model_step(input logic v, input logic [W-1:0] q);
        int k;
        bit ill, se, iv;
        k = -1; ill = 0; se = 0; iv = 0;
        if (v) begin
            for (int i = 0; i < SEQ; i++) if (codes[i] == q) k = i;
            if (k < 0) begin
                ill = 1;
                m_err = (m_err < 255) ? m_err + 1 : 255;
                m_run = 0;
                if (m_locked) begin
                    m_locked = 0;
                    m_ref_valid = 0;
                end
            end else begin
                bit hit;
                hit = m_ref_valid && (k == (m_idx + 1) % SEQ);
                if (m_locked) begin
                    if (!hit) begin
                        se = 1;
                        m_err = (m_err < 255) ? m_err + 1 : 255;
                        m_locked = 0;
                        m_run = 0;
                    end
                end else if (hit) begin
                    m_run++;
                    if (m_run >= LOCKN) begin
                        m_locked = 1;
                        m_run = 0;
                    end
                end else begin
                    m_run = 0;
                end
                m_idx = k;
                m_ref_valid = 1;
                iv = 1;
            end
        end
        exp_q.push_back(pack(m_idx, iv, ill, se, m_locked, m_err));
    endtask

    // Drive one sample; outputs are checked #1 after the edge that captured it.
    task automatic step(input logic v, input logic [W-1:0] q);
        logic [OUT_W-1:0] e;
        @(negedge clk);
        valid_in = v;
        q_in = q;
        model_step(v, q);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("scoreboard", 32'(actual()), 32'(e));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        valid_in = 1'b0;
        q_in = '0;
        model_reset();
        @(negedge clk);
        check("reset_outputs", 32'(actual()), 32'(pack(0, 0, 0, 0, 0, 0)));
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] c;
        c = '0;
        for (int i = 0; i < SEQ; i++) begin
            codes[i] = c;
            c = {~c[0], c[W-1:1]};
        end
        bad_codes[0] = 4'b0100; bad_codes[1] = 4'b0010; bad_codes[2] = 4'b1010;
        bad_codes[3] = 4'b0101; bad_codes[4] = 4'b1001; bad_codes[5] = 4'b1011;
        bad_codes[6] = 4'b1101; bad_codes[7] = 4'b0110;

        // full walk, wrap, illegal while locked, reseed and relock
        vecs[0]  = mk(1, 4'b0000, pack(0, 1, 0, 0, 0, 0));
        vecs[1]  = mk(1, 4'b1000, pack(1, 1, 0, 0, 0, 0));
        vecs[2]  = mk(1, 4'b1100, pack(2, 1, 0, 0, 1, 0));
        vecs[3]  = mk(1, 4'b1110, pack(3, 1, 0, 0, 1, 0));
        vecs[4]  = mk(1, 4'b1111, pack(4, 1, 0, 0, 1, 0));
        vecs[5]  = mk(1, 4'b0111, pack(5, 1, 0, 0, 1, 0));
        vecs[6]  = mk(1, 4'b0011, pack(6, 1, 0, 0, 1, 0));
        vecs[7]  = mk(1, 4'b0001, pack(7, 1, 0, 0, 1, 0));
        vecs[8]  = mk(1, 4'b0000, pack(0, 1, 0, 0, 1, 0));
        vecs[9]  = mk(1, 4'b1000, pack(1, 1, 0, 0, 1, 0));
        vecs[10] = mk(1, 4'b1100, pack(2, 1, 0, 0, 1, 0));
        vecs[11] = mk(1, 4'b1110, pack(3, 1, 0, 0, 1, 0));
        vecs[12] = mk(1, 4'b1010, pack(3, 0, 1, 0, 0, 1));
        vecs[13] = mk(1, 4'b1111, pack(4, 1, 0, 0, 0, 1));
        vecs[14] = mk(1, 4'b0111, pack(5, 1, 0, 0, 0, 1));
        vecs[15] = mk(1, 4'b0011, pack(6, 1, 0, 0, 1, 1));

        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(vecs[i].v, vecs[i].q);
            check($sformatf("vec%0d", i), 32'(actual()), 32'(vecs[i].exp));
        end
        step(0, 4'b0001);
        check("idle_hold", 32'(actual()), 32'(pack(6, 0, 0, 0, 1, 1)));

        // seq_err while locked, then relock after two correct steps
        do_reset();
        step(1, 4'b0000);
        step(1, 4'b1000);
        step(1, 4'b1100);
        check("lock_at_2", 32'(locked), 32'(1));
        step(1, 4'b1111);
        check("seq_err_pulse", 32'(actual()), 32'(pack(4, 1, 0, 1, 0, 1)));
        step(1, 4'b0111);
        check("relock_wait", 32'(actual()), 32'(pack(5, 1, 0, 0, 0, 1)));
        step(1, 4'b0011);
        check("relocked", 32'(actual()), 32'(pack(6, 1, 0, 0, 1, 1)));

        // err_count saturation
        do_reset();
        for (int i = 0; i < 300; i++) step(1, bad_codes[$urandom_range(0, 7)]);
        check("err_saturate", 32'(err_count), 32'(255));
        check("sat_illegal_pulse", 32'(illegal), 32'(1));
        check("sat_idx_hold", 32'(idx), 32'(0));

        // asynchronous reset between edges while locked
        do_reset();
        step(1, 4'b0000);
        step(1, 4'b1000);
        step(1, 4'b1100);
        step(1, 4'b1110);
        valid_in = 1'b0;
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("async_reset_clear", 32'(actual()), 32'(pack(0, 0, 0, 0, 0, 0)));
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step(0, 4'b1111);
        check("post_reset_idle", 32'(actual()), 32'(pack(0, 0, 0, 0, 0, 0)));
        step(1, 4'b1000);
        check("seed_only", 32'(actual()), 32'(pack(1, 1, 0, 0, 0, 0)));
        step(1, 4'b1100);
        step(1, 4'b1110);
        check("lock_after_seed", 32'(actual()), 32'(pack(3, 1, 0, 0, 1, 0)));

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 500; i++) begin
            logic v;
            logic [W-1:0] q;
            v = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) < 7) q = codes[(m_idx + 1) % SEQ];
            else q = W'($urandom_range(0, 15));
            step(v, q);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/johnson_decoder_monitor.md
JOHNSON_DECODER_MONITOR -- requirements
Module: johnson_decoder_monitor

Interface
REQ-001 Parameter WIDTH, default 4: Johnson register width; legal sequence length 2*WIDTH.
REQ-002 Parameter IDX_W, default 3: index width; SHALL satisfy 2^IDX_W >= 2*WIDTH.
REQ-003 Parameter LOCK_N, default 2: consecutive correct successors required to reach LOCKED.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high; clears all state immediately on assertion.
REQ-006 valid_in  input  1  q_in holds a new counter step this cycle.
REQ-007 q_in  input  WIDTH  sampled Johnson counter state.
REQ-008 idx  output  IDX_W  registered decoded step index.
REQ-009 idx_valid  output  1  one-cycle pulse: idx updated from a legal sample.
REQ-010 illegal  output  1  one-cycle pulse: sample is not a legal Johnson code.
REQ-011 seq_err  output  1  one-cycle pulse: legal code while LOCKED, but not the expected successor.
REQ-012 locked  output  1  high in state LOCKED.
REQ-013 err_count  output  8  saturating count of illegal plus seq_err events.

Function
REQ-014 Legal sequence, index 0..2*WIDTH-1, generated by next = {~q[0], q[WIDTH-1:1]}; for WIDTH=4: 0000,1000,1100,1110,1111,0111,0011,0001.
REQ-015 Decode: for k in 0..WIDTH, the top k bits are 1 and the rest are 0; for k in WIDTH+1..2*WIDTH-1, the top k-WIDTH bits are 0 and the rest are 1; all other codes are illegal.
REQ-016 Latency: exactly one cycle from a valid_in sample to its idx, idx_valid, illegal and seq_err.
REQ-017 When valid_in is low, no pulses are generated; idx, state, lock counter and err_count hold.
REQ-018 On an illegal sample, idx holds its previous value and idx_valid stays low.
REQ-019 Expected successor = (last legal idx + 1) mod 2*WIDTH; wrap 2*WIDTH-1 -> 0 is correct.
REQ-020 FSM states: UNLOCKED and LOCKED. Reset state is UNLOCKED.
REQ-021 UNLOCKED, legal sample that is the expected successor of the previous legal sample: lock counter increments. Any other legal sample: lock counter = 0 and the sample becomes the new reference.
REQ-022 UNLOCKED: the transition to LOCKED occurs when the lock counter reaches LOCK_N; locked rises in the same cycle as that sample's idx_valid.
REQ-023 UNLOCKED: an illegal sample pulses illegal, increments err_count and clears the lock counter; seq_err never pulses in UNLOCKED.
REQ-024 LOCKED, expected successor: stay LOCKED.
REQ-025 LOCKED, legal non-successor: pulse seq_err, update idx, pulse idx_valid, go UNLOCKED, set lock counter = 0, and use this sample as the new reference.
REQ-026 LOCKED, illegal sample: pulse illegal, go UNLOCKED, clear the lock counter, and invalidate the reference so the next legal sample only re-seeds it.
REQ-027 illegal and seq_err are mutually exclusive; illegal takes precedence.
REQ-028 err_count increments by 1 per illegal or seq_err pulse and saturates at 255 without wrapping.

Reset
REQ-029 While reset is high, all outputs are held at: idx=0, idx_valid=0, illegal=0, seq_err=0, locked=0, err_count=0.
REQ-030 While reset is high: state=UNLOCKED, lock counter=0, reference invalid.
REQ-031 Reset asserted mid-sequence takes effect without a clock edge.
REQ-032 After reset release, the first legal sample only seeds the reference.

Verification
REQ-033 Reset pulse, then 8 valid legal steps from 0000 (WIDTH=4, LOCK_N=2) -> idx 0..7 with a 1-cycle lag; locked rises with the idx=2 sample; err_count=0.
REQ-034 Locked, run past 0001 back to 0000 -> wrap 7->0 accepted; locked stays 1; no pulses.
REQ-035 Locked at idx=3 (1110), inject 1010 -> illegal pulses once; locked=0; err_count=1; idx stays 3.
REQ-036 Locked at idx=2 (1100), inject 1111 (idx 4) -> seq_err pulses; idx=4; locked=0; relock after the next 2 correct steps (0111, 0011).
REQ-037 Drive 300 illegal samples -> err_count saturates at 255.
REQ-038 Assert reset asynchronously between clock edges while locked -> outputs clear immediately; with valid_in held low, everything stays cleared after release.
